// File: rtl/frog_ctrl.sv
// Frog position and life-cycle controller: debounced buttons, per-frame animated
// grid hops, collision death/respawn, top-row win, and lives/game-over tracking.
module frog_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int TILE            = 32,
    parameter int HOP_STEP        = 4,
    parameter int FIELD_X_MIN     = 96,
    parameter int FIELD_X_MAX     = 512,
    parameter int FIELD_Y_MAX     = 448,
    parameter int START_X         = 288,
    parameter int START_Y         = 448,
    parameter int DEAD_FRAMES     = 60,
    parameter int WIN_FRAMES      = 30,
    parameter int LIVES           = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       frame_tick,
    input  logic       collision,
    output logic [9:0] frog_x,
    output logic [9:0] frog_y,
    output logic [9:0] frog_size,
    output logic [1:0] lives,
    output logic       score_pulse,
    output logic       hop_active,
    output logic       dead,
    output logic       game_over
);

    localparam int STEPS      = TILE / HOP_STEP;
    localparam int MAX_FRAMES = (DEAD_FRAMES > WIN_FRAMES) ? DEAD_FRAMES : WIN_FRAMES;
    localparam int DB_W       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int FC_W       = $clog2(MAX_FRAMES + 1);
    localparam int SC_W       = $clog2(STEPS + 1);

    localparam logic [10:0] TILE_W      = 11'(TILE);
    localparam logic [10:0] X_MIN_W     = 11'(FIELD_X_MIN);
    localparam logic [10:0] X_MAX_W     = 11'(FIELD_X_MAX);
    localparam logic [10:0] Y_MAX_W     = 11'(FIELD_Y_MAX);
    localparam logic [9:0]  STEP_W      = 10'(HOP_STEP);
    localparam logic [9:0]  START_X_W   = 10'(START_X);
    localparam logic [9:0]  START_Y_W   = 10'(START_Y);
    localparam logic [1:0]  LIVES_W     = 2'(LIVES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOP,
        S_DEAD,
        S_WIN,
        S_GAME_OVER
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    // ------------------------------------------------------------------
    // Button input path: bit 0 up, 1 down, 2 left, 3 right
    // ------------------------------------------------------------------
    logic [3:0]      btn_raw;
    logic [3:0]      sync1;
    logic [3:0]      sync2;
    logic [3:0]      deb;
    logic [3:0]      deb_d;
    logic [3:0]      press;
    logic [DB_W-1:0] db_cnt [4];

    assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            // NOTE: the counter array is only four registers, so it is reset
            // like any other state; a large RAM-style array would not be.
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            deb_d <= deb;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        deb[i]    <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign press = deb & ~deb_d;

    // Fixed priority up > down > left > right; only the winner is considered.
    logic press_any;
    dir_t press_dir;

    always_comb begin
        press_any = |press;
        press_dir = DIR_UP;
        if (press[0])      press_dir = DIR_UP;
        else if (press[1]) press_dir = DIR_DOWN;
        else if (press[2]) press_dir = DIR_LEFT;
        else if (press[3]) press_dir = DIR_RIGHT;
    end

    // ------------------------------------------------------------------
    // Game state
    // ------------------------------------------------------------------
    state_t          state,     state_n;
    dir_t            dir_q,     dir_n;
    logic [9:0]      pos_x,     pos_x_n;
    logic [9:0]      pos_y,     pos_y_n;
    logic [1:0]      lives_q,   lives_n;
    logic [SC_W-1:0] step_cnt,  step_cnt_n;
    logic [FC_W-1:0] frame_cnt, frame_cnt_n;
    logic            score_q;

    // Target tile must stay inside the field; checked before any motion starts.
    logic in_bounds;
    logic [10:0] x_w, y_w;

    always_comb begin
        x_w = {1'b0, pos_x};
        y_w = {1'b0, pos_y};
        in_bounds = 1'b0;
        case (press_dir)
            DIR_UP:    in_bounds = (y_w >= TILE_W);
            DIR_DOWN:  in_bounds = (y_w + TILE_W <= Y_MAX_W);
            DIR_LEFT:  in_bounds = (x_w >= X_MIN_W + TILE_W);
            DIR_RIGHT: in_bounds = (x_w + TILE_W <= X_MAX_W);
            default:   in_bounds = 1'b0;
        endcase
    end

    logic [9:0] step_x, step_y;

    always_comb begin
        step_x = pos_x;
        step_y = pos_y;
        case (dir_q)
            DIR_UP:    step_y = pos_y - STEP_W;
            DIR_DOWN:  step_y = pos_y + STEP_W;
            DIR_LEFT:  step_x = pos_x - STEP_W;
            DIR_RIGHT: step_x = pos_x + STEP_W;
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            dir_q     <= DIR_UP;
            pos_x     <= START_X_W;
            pos_y     <= START_Y_W;
            lives_q   <= LIVES_W;
            step_cnt  <= '0;
            frame_cnt <= '0;
            score_q   <= 1'b0;
        end else begin
            // NOTE: state registers take non-blocking assignments so every
            // register samples the pre-edge values computed in always_comb.
            state     <= state_n;
            dir_q     <= dir_n;
            pos_x     <= pos_x_n;
            pos_y     <= pos_y_n;
            lives_q   <= lives_n;
            step_cnt  <= step_cnt_n;
            frame_cnt <= frame_cnt_n;
            score_q   <= (state_n == S_WIN) && (state != S_WIN);
        end
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first, so no path
        // through the case leaves a variable unassigned and no latch appears.
        state_n     = state;
        dir_n       = dir_q;
        pos_x_n     = pos_x;
        pos_y_n     = pos_y;
        lives_n     = lives_q;
        step_cnt_n  = step_cnt;
        frame_cnt_n = frame_cnt;

        case (state)
            S_IDLE: begin
                if (collision) begin
                    state_n     = S_DEAD;
                    lives_n     = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
                    frame_cnt_n = '0;
                end else if (press_any && in_bounds) begin
                    state_n    = S_HOP;
                    dir_n      = press_dir;
                    step_cnt_n = '0;
                end
            end

            S_HOP: begin
                if (collision) begin
                    state_n     = S_DEAD;
                    lives_n     = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
                    frame_cnt_n = '0;
                end else if (frame_tick) begin
                    pos_x_n    = step_x;
                    pos_y_n    = step_y;
                    step_cnt_n = step_cnt + 1'b1;
                    if (step_cnt == SC_W'(STEPS - 1)) begin
                        state_n     = (step_y == 10'd0) ? S_WIN : S_IDLE;
                        step_cnt_n  = '0;
                        frame_cnt_n = '0;
                    end
                end
            end

            S_DEAD: begin
                if (frame_tick) begin
                    frame_cnt_n = frame_cnt + 1'b1;
                    if (frame_cnt == FC_W'(DEAD_FRAMES - 1)) begin
                        frame_cnt_n = '0;
                        if (lives_q == 2'd0) begin
                            state_n = S_GAME_OVER;
                        end else begin
                            state_n = S_IDLE;
                            pos_x_n = START_X_W;
                            pos_y_n = START_Y_W;
                        end
                    end
                end
            end

            S_WIN: begin
                if (frame_tick) begin
                    frame_cnt_n = frame_cnt + 1'b1;
                    if (frame_cnt == FC_W'(WIN_FRAMES - 1)) begin
                        frame_cnt_n = '0;
                        state_n     = S_IDLE;
                        pos_x_n     = START_X_W;
                        pos_y_n     = START_Y_W;
                    end
                end
            end

            S_GAME_OVER: begin
                // Restart only; the restarting press never doubles as a hop.
                if (press_any) begin
                    state_n = S_IDLE;
                    lives_n = LIVES_W;
                    pos_x_n = START_X_W;
                    pos_y_n = START_Y_W;
                end
            end

            default: state_n = S_IDLE;
        endcase
    end

    assign frog_x      = pos_x;
    assign frog_y      = pos_y;
    assign frog_size   = 10'(TILE);
    assign lives       = lives_q;
    assign score_pulse = score_q;
    assign hop_active  = (state == S_HOP);
    assign dead        = (state == S_DEAD);
    assign game_over   = (state == S_GAME_OVER);

endmodule

// File: tb/tb_frog_ctrl.sv
// Self-checking bench for frog_ctrl: hop positions are pushed to a scoreboard as
// frame ticks are driven and popped when the DUT shows the stepped position.
module tb_frog_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic       frame_tick = 1'b0;
    logic       collision = 1'b0;
    logic [9:0] frog_x, frog_y, frog_size;
    logic [1:0] lives;
    logic       score_pulse, hop_active, dead, game_over;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
    } pos_t;

    pos_t sb_q[$];
    logic [9:0] exp_x, exp_y;

    frog_ctrl #(.DEBOUNCE_CYCLES(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .frame_tick  (frame_tick),
        .collision   (collision),
        .frog_x      (frog_x),
        .frog_y      (frog_y),
        .frog_size   (frog_size),
        .lives       (lives),
        .score_pulse (score_pulse),
        .hop_active  (hop_active),
        .dead        (dead),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_x = 10'd288;
        exp_y = 10'd448;
    endtask

    // Holds the mask long enough for the debounced press, then releases it fully.
    task automatic press_btn(input logic [3:0] mask);
        @(negedge clk);
        {btn_right, btn_left, btn_down, btn_up} = mask;
        repeat (24) @(negedge clk);
        {btn_right, btn_left, btn_down, btn_up} = 4'b0000;
        repeat (24) @(negedge clk);
    endtask

    task automatic do_tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic do_collide();
        @(negedge clk);
        collision = 1'b1;
        @(negedge clk);
        collision = 1'b0;
    endtask

    // Step n ticks of a hop; each tick pushes the expected position and the
    // cycle after the tick pops and compares it.
    task automatic step_hop(input int n, input int dx, input int dy);
        pos_t e, got;
        for (int i = 0; i < n; i++) begin
            exp_x = 10'(int'(exp_x) + dx);
            exp_y = 10'(int'(exp_y) + dy);
            e.x = exp_x;
            e.y = exp_y;
            sb_q.push_back(e);
            do_tick();
            got = sb_q.pop_front();
            checks++;
            if (frog_x !== got.x || frog_y !== got.y) begin
                errors++;
                $display("FAIL hop_step%0d: got (%0d,%0d) expected (%0d,%0d)",
                         i + 1, frog_x, frog_y, got.x, got.y);
            end
        end
    endtask

    task automatic run_hop(input logic [3:0] mask, input int dx, input int dy);
        press_btn(mask);
        checks++;
        if (hop_active !== 1'b1) begin
            errors++;
            $display("FAIL hop_start: hop_active=%0b expected 1", hop_active);
        end
        step_hop(8, dx, dy);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (frog_x !== 10'd288 || frog_y !== 10'd448 || lives !== 2'd3 || frog_size !== 10'd32) begin
            errors++;
            $display("FAIL reset_values: x=%0d y=%0d lives=%0d size=%0d expected 288 448 3 32",
                     frog_x, frog_y, lives, frog_size);
        end
        checks++;
        if ({score_pulse, hop_active, dead, game_over} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: flags=%b expected 0000",
                     {score_pulse, hop_active, dead, game_over});
        end
    endtask

    task automatic test_glitch_and_hop();
        apply_reset();
        @(negedge clk);
        btn_up = 1'b1;
        repeat (10) @(negedge clk);
        btn_up = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (hop_active !== 1'b0 || frog_y !== 10'd448) begin
            errors++;
            $display("FAIL glitch_rejected: hop_active=%0b y=%0d expected 0 448", hop_active, frog_y);
        end
        run_hop(4'b0001, 0, -4);
        checks++;
        if (hop_active !== 1'b0 || frog_y !== 10'd416) begin
            errors++;
            $display("FAIL hop_done: hop_active=%0b y=%0d expected 0 416", hop_active, frog_y);
        end
        // Up beats down when both fire together.
        run_hop(4'b0011, 0, -4);
    endtask

    task automatic test_bounds();
        apply_reset();
        for (int h = 0; h < 6; h++) run_hop(4'b0100, -4, 0);
        press_btn(4'b0100);
        checks++;
        if (hop_active !== 1'b0 || frog_x !== 10'd96) begin
            errors++;
            $display("FAIL left_edge: hop_active=%0b x=%0d expected 0 96", hop_active, frog_x);
        end
        press_btn(4'b1100);
        checks++;
        if (hop_active !== 1'b0 || frog_x !== 10'd96) begin
            errors++;
            $display("FAIL left_right_prio: hop_active=%0b x=%0d expected 0 96", hop_active, frog_x);
        end
        press_btn(4'b0010);
        checks++;
        if (hop_active !== 1'b0 || frog_y !== 10'd448) begin
            errors++;
            $display("FAIL bottom_edge: hop_active=%0b y=%0d expected 0 448", hop_active, frog_y);
        end
    endtask

    task automatic test_press_in_hop();
        apply_reset();
        press_btn(4'b0001);
        press_btn(4'b1000);
        step_hop(8, 0, -4);
        repeat (30) @(negedge clk);
        checks++;
        if (hop_active !== 1'b0 || frog_x !== 10'd288 || frog_y !== 10'd416) begin
            errors++;
            $display("FAIL press_in_hop_dropped: hop=%0b x=%0d y=%0d expected 0 288 416",
                     hop_active, frog_x, frog_y);
        end
    endtask

    task automatic test_reset_mid_hop();
        apply_reset();
        press_btn(4'b0001);
        step_hop(2, 0, -4);
        apply_reset();
        do_tick();
        checks++;
        if (hop_active !== 1'b0 || frog_y !== 10'd448 || frog_x !== 10'd288) begin
            errors++;
            $display("FAIL reset_mid_hop: hop=%0b x=%0d y=%0d expected 0 288 448",
                     hop_active, frog_x, frog_y);
        end
    endtask

    task automatic test_collision();
        apply_reset();
        press_btn(4'b0001);
        step_hop(3, 0, -4);
        do_collide();
        checks++;
        if (dead !== 1'b1 || lives !== 2'd2 || hop_active !== 1'b0 || frog_y !== 10'd436) begin
            errors++;
            $display("FAIL collide_entry: dead=%0b lives=%0d hop=%0b y=%0d expected 1 2 0 436",
                     dead, lives, hop_active, frog_y);
        end
        do_collide();
        for (int t = 0; t < 59; t++) do_tick();
        checks++;
        if (dead !== 1'b1 || lives !== 2'd2 || frog_y !== 10'd436) begin
            errors++;
            $display("FAIL dead_hold: dead=%0b lives=%0d y=%0d expected 1 2 436", dead, lives, frog_y);
        end
        do_tick();
        checks++;
        if (dead !== 1'b0 || frog_x !== 10'd288 || frog_y !== 10'd448 || hop_active !== 1'b0) begin
            errors++;
            $display("FAIL respawn: dead=%0b x=%0d y=%0d hop=%0b expected 0 288 448 0",
                     dead, frog_x, frog_y, hop_active);
        end
    endtask

    task automatic test_game_over();
        for (int k = 1; k >= 0; k--) begin
            do_collide();
            checks++;
            if (dead !== 1'b1 || lives !== 2'(k)) begin
                errors++;
                $display("FAIL lives_dec: dead=%0b lives=%0d expected 1 %0d", dead, lives, k);
            end
            for (int t = 0; t < 60; t++) do_tick();
        end
        checks++;
        if (game_over !== 1'b1 || dead !== 1'b0 || lives !== 2'd0) begin
            errors++;
            $display("FAIL game_over_entry: go=%0b dead=%0b lives=%0d expected 1 0 0",
                     game_over, dead, lives);
        end
        press_btn(4'b0010);
        do_tick();
        checks++;
        if (game_over !== 1'b0 || lives !== 2'd3 || frog_x !== 10'd288 || frog_y !== 10'd448 ||
            hop_active !== 1'b0) begin
            errors++;
            $display("FAIL restart: go=%0b lives=%0d x=%0d y=%0d hop=%0b expected 0 3 288 448 0",
                     game_over, lives, frog_x, frog_y, hop_active);
        end
    endtask

    task automatic test_win();
        apply_reset();
        for (int h = 0; h < 13; h++) run_hop(4'b0001, 0, -4);
        checks++;
        if (frog_y !== 10'd32 || score_pulse !== 1'b0) begin
            errors++;
            $display("FAIL pre_win: y=%0d score=%0b expected 32 0", frog_y, score_pulse);
        end
        run_hop(4'b0001, 0, -4);
        checks++;
        if (score_pulse !== 1'b1 || hop_active !== 1'b0) begin
            errors++;
            $display("FAIL score_pulse_on: score=%0b hop=%0b expected 1 0", score_pulse, hop_active);
        end
        @(negedge clk);
        checks++;
        if (score_pulse !== 1'b0) begin
            errors++;
            $display("FAIL score_pulse_off: score=%0b expected 0", score_pulse);
        end
        do_collide();
        for (int t = 0; t < 29; t++) do_tick();
        checks++;
        if (dead !== 1'b0 || lives !== 2'd3 || frog_y !== 10'd0) begin
            errors++;
            $display("FAIL win_hold: dead=%0b lives=%0d y=%0d expected 0 3 0", dead, lives, frog_y);
        end
        do_tick();
        checks++;
        if (frog_x !== 10'd288 || frog_y !== 10'd448 || lives !== 2'd3 || hop_active !== 1'b0) begin
            errors++;
            $display("FAIL win_respawn: x=%0d y=%0d lives=%0d hop=%0b expected 288 448 3 0",
                     frog_x, frog_y, lives, hop_active);
        end
    endtask

    initial begin
        test_reset();
        test_glitch_and_hop();
        test_bounds();
        test_press_in_hop();
        test_reset_mid_hop();
        test_collision();
        test_game_over();
        test_win();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frog_ctrl.md
Name: frog_ctrl

Overview:
Owns the frog's position and life cycle and drives the frog_x/frog_y/frog_size inputs of the frog pixel generator. It debounces the four board direction buttons and runs grid hops animated once per video frame. It also handles collision death, respawn, the win at the top row, and lives and game-over state. It runs on the pixel clock and takes a one-cycle frame_tick from the VGA timing block.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable clk cycles required before a synchronized button level is accepted
TILE, 32, grid pitch and frog_size in pixels
HOP_STEP, 4, pixels moved per frame_tick during a hop (TILE/HOP_STEP = 8 frames per hop)
FIELD_X_MIN, 96, leftmost legal frog_x
FIELD_X_MAX, 512, rightmost legal frog_x (frog covers 512..543)
FIELD_Y_MAX, 448, bottom legal frog_y
START_X, 288, respawn frog_x
START_Y, 448, respawn frog_y
DEAD_FRAMES, 60, frames held in DEAD
WIN_FRAMES, 30, frames held in WIN
LIVES, 3, lives at reset and at restart

Ports:
clk  in  1  pixel clock; single clock domain
rst_n  in  1  synchronous active-low reset
btn_up, btn_down, btn_left, btn_right  in  1 each  raw asynchronous buttons, active-high
frame_tick  in  1  one-cycle pulse per frame, start of vblank
collision  in  1  level, frog overlaps a hazard this cycle
frog_x  out  10  frog left edge, pixels
frog_y  out  10  frog top edge, pixels
frog_size  out  10  constant TILE
lives  out  2  remaining lives
score_pulse  out  1  one-cycle pulse on entering WIN
hop_active  out  1  high in HOP
dead  out  1  high in DEAD
game_over  out  1  high in GAME_OVER

Behaviour:
- Reset (rst_n low at a clk edge) produces:
  - frog_x=START_X, frog_y=START_Y, lives=LIVES, state IDLE.
  - score_pulse, hop_active, dead and game_over all 0.
  - Synchronizers and debounced levels cleared to 0; debounce counters cleared.
- Reset mid-hop or mid-DEAD aborts immediately to the reset state. No residual motion.
- Input path, per button:
  - 2-FF synchronizer, then debounce.
  - Debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles. Any return to the old value restarts the count.
  - press = one-cycle rising edge of the debounced level.
  - Latency from a clean raw edge to press: 2 + DEBOUNCE_CYCLES + 1 cycles.
- Press priority when several fire in the same cycle: up > down > left > right. Only one is used.
- Presses outside IDLE and GAME_OVER are discarded, not queued.
- IDLE:
  - A press whose target tile lies in bounds latches the direction; next cycle is HOP.
  - Bounds: x in [FIELD_X_MIN, FIELD_X_MAX], y in [0, FIELD_Y_MAX]. Target = current ± TILE.
  - An out-of-bounds press is ignored; state and position are unchanged.
- HOP:
  - On each frame_tick, the position moves HOP_STEP in the latched direction (up = y decreases); the output updates on the cycle after frame_tick.
  - A frame_tick coincident with the accepting press does not step.
  - After TILE/HOP_STEP steps, the position equals the target exactly. Next state is WIN if frog_y==0, else IDLE.
- Collision:
  - Sampled in IDLE and HOP; it beats a coincident press or step.
  - Next state is DEAD, lives decremented by 1 on entry, position frozen.
  - Ignored in DEAD, WIN and GAME_OVER.
- DEAD: counts DEAD_FRAMES frame_ticks. Then, if lives==0, go to GAME_OVER (position held). Otherwise respawn at START_X/START_Y and go to IDLE.
- WIN: score_pulse=1 for the entry cycle only. After WIN_FRAMES frame_ticks, respawn and go to IDLE. Lives are unchanged.
- GAME_OVER: any press restores lives=LIVES, respawns, and goes to IDLE. The press does not also hop.
- Arithmetic: all 10-bit unsigned. Bounds are checked before the hop starts, so no wrap is possible.

Test Plan:
- Reset -> frog_x=288, frog_y=448, lives=3, frog_size=32, all flags 0.
- DEBOUNCE_CYCLES=16; 10-cycle btn_up glitch -> no press. Then held btn_up -> hop_active=1. Over 8 frame_ticks frog_y steps 444, 440, ..., 416 (each update 1 cycle after its tick), then IDLE.
- Frog at x=96, btn_left -> ignored, x stays 96. Simultaneous btn_left+btn_right -> left wins, ignored, no move.
- Collision at hop step 3 (frog_y=436) -> dead=1, lives=2, frog_y=436 held 60 ticks, then respawn at (288,448) in IDLE.
- Three collisions -> lives=0, game_over=1 after 60 ticks. btn_down -> lives=3, frog at (288,448), no hop.
- Frog at y=32, btn_up, 8 ticks -> frog_y=0, score_pulse one cycle, collision ignored for 30 ticks, then respawn.
